// File: rtl/cordic_pkg.sv
// Shared constants for the hyperbolic-vectoring CORDIC square-root core.
// Contents: datapath widths, FSM state encoding, Q2.17 constants, and the
// 17-entry shift schedule (index 0 at the LSB) with its lookup function.
package cordic_pkg;

    localparam int unsigned W      = 20;  // signed datapath width
    localparam int unsigned FRAC   = 17;  // fractional bits (Q2.17)
    localparam int unsigned N_ITER = 17;  // iteration count
    localparam int unsigned SH_W   = 4;   // shift-amount width
    localparam int unsigned CNT_W  = 5;   // iteration counter width

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_COMP = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    localparam logic [W-1:0] QUARTER = 20'h08000;  // +0.25
    localparam logic [W-1:0] MAX_IN  = 20'h40000;  // +2.0

    // Hyperbolic schedule 1,2,3,4,4,5..13,13,14,15; shifts 4 and 13 repeat for convergence.
    localparam logic [N_ITER*SH_W-1:0] SHIFT_SCHED = {
        4'd15, 4'd14, 4'd13, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9,
        4'd8,  4'd7,  4'd6,  4'd5,  4'd4,  4'd4,  4'd3,  4'd2, 4'd1
    };

    // Schedule lookup; out-of-range indices return 0.
    function automatic logic [SH_W-1:0] sched_shift(input logic [CNT_W-1:0] idx);
        logic [SH_W-1:0] sh;
        sh = '0;
        for (int unsigned i = 0; i < N_ITER; i++) begin
            if (idx == CNT_W'(i)) sh = SHIFT_SCHED[i*SH_W +: SH_W];
        end
        return sh;
    endfunction

endpackage

// File: rtl/cordic_iter_sched.sv
// Iteration sequencer: counter register, schedule lookup, last-iteration flag.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   en_i        high in ITER; sh_amt_o reads 0 otherwise
//   clr_i       restart the count at 0
//   adv_i       advance one iteration (wraps to 0 after the last)
//   sh_amt_o    current shift index (combinational from the count)
//   last_o      count is at N_ITER-1
module cordic_iter_sched
    import cordic_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    input  logic            clr_i,
    input  logic            adv_i,
    output logic [SH_W-1:0] sh_amt_o,
    output logic            last_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign last_o   = (count_q == CNT_W'(N_ITER - 1));
    assign sh_amt_o = en_i ? sched_shift(count_q) : '0;

    // Next count: clear has priority, then advance with wrap at the last iteration.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (adv_i) begin
            count_d = last_o ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

endmodule

// File: rtl/cordic_hyp_sqrt_core.sv
// Iterative hyperbolic-vectoring CORDIC computing sqrt(a) on a Q2.17 operand.
// Starts from x = a + 0.25, y = a - 0.25 so that x^2 - y^2 = a; after the
// schedule x holds K_h*sqrt(a). The shifters are external: this block drives
// sh_amt/x_q/y_q and consumes the shifted x_sh/y_sh the same cycle.
// Optional macro CORDIC_GAIN_COMP_EN adds a COMP cycle that multiplies by ~1/K_h.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, a_in         request and operand (sampled only in IDLE)
//   busy, done          busy in every non-IDLE state; done pulses in FIN
//   result, err         sqrt result (Q2.17) and out-of-range flag, held until next done
//   sh_amt, x_q, y_q    shift index and registers driven to the shifters
//   x_sh, y_sh          arithmetic x_q>>>sh_amt, y_q>>>sh_amt from the shifters
module cordic_hyp_sqrt_core
    import cordic_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [W-1:0]    a_in,
    output logic            busy,
    output logic            done,
    output logic [W-1:0]    result,
    output logic            err,
    output logic [SH_W-1:0] sh_amt,
    output logic [W-1:0]    x_q,
    output logic [W-1:0]    y_q,
    input  logic [W-1:0]    x_sh,
    input  logic [W-1:0]    y_sh
);

    logic [1:0]   state_q, state_d;
    logic [W-1:0] x_d, y_d;
    logic [W-1:0] result_q, result_d;
    logic         err_q, err_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         clr_c, adv_c, last_c, in_range_c;

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign err    = err_q;

    // Valid operands lie in (0, 2.0]; non-negative values compare correctly unsigned.
    assign in_range_c = !a_in[W-1] && (a_in != '0) && (a_in <= MAX_IN);

    cordic_iter_sched u_sched (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (state_q == ST_ITER),
        .clr_i    (clr_c),
        .adv_i    (adv_c),
        .sh_amt_o (sh_amt),
        .last_o   (last_c)
    );

`ifdef CORDIC_GAIN_COMP_EN
    localparam int unsigned SUM_W = W + 3;
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(20'h7FFFF);
    logic signed [SUM_W-1:0] x_ext_c, comp_sum_c;
    logic        [W-1:0]     comp_res_c;

    // x * (1 + 2^-3 + 2^-4 + 2^-6 + 2^-8 + 2^-11) ~= x / K_h, with headroom for saturation.
    always_comb begin
        x_ext_c    = {{(SUM_W-W){x_q[W-1]}}, x_q};
        comp_sum_c = x_ext_c + (x_ext_c >>> 3) + (x_ext_c >>> 4) + (x_ext_c >>> 6)
                   + (x_ext_c >>> 8) + (x_ext_c >>> 11);
        comp_res_c = (comp_sum_c > SAT_MAX) ? 20'h7FFFF : W'(comp_sum_c);
    end
`endif

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        result_d = result_q;
        err_d    = err_q;
        clr_c    = 1'b0;
        adv_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (!in_range_c) begin
                        err_d    = 1'b1;
                        result_d = '0;
                        state_d  = ST_FIN;
                    end else begin
                        x_d     = a_in + QUARTER;
                        y_d     = a_in - QUARTER;
                        err_d   = 1'b0;
                        clr_c   = 1'b1;
                        state_d = ST_ITER;
                    end
                end
            end
            ST_ITER: begin
                adv_c = 1'b1;
                // Rotate towards y = 0; both updates read the old register values.
                if (y_q[W-1]) begin
                    x_d = x_q + y_sh;
                    y_d = y_q + x_sh;
                end else begin
                    x_d = x_q - y_sh;
                    y_d = y_q - x_sh;
                end
                if (last_c) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_d = ST_COMP;
`else
                    result_d = x_d;
                    state_d  = ST_FIN;
`endif
                end
            end
`ifdef CORDIC_GAIN_COMP_EN
            ST_COMP: begin
                result_d = comp_res_c;
                state_d  = ST_FIN;
            end
`endif
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FIN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            result_q <= result_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: doc/cordic_hyp_sqrt_core.md
Name: cordic_hyp_sqrt_core

Overview:
- Iterative hyperbolic-vectoring CORDIC engine computing sqrt(a) for one 20-bit fixed-point operand.
- Sits directly upstream of, and drives, the 20-bit arithmetic right shifters (4-bit select) in the square-root datapath.
- Each clock it issues the current iteration index as the shift amount and consumes the shifted x/y terms.
- Start/busy/done handshake toward the control/test wrapper.

Parameters:
- W, 20, datapath width (signed two's complement); fixed by the shifter width.
- FRAC, 17, fractional bits; format is sign + 2 integer + 17 fraction, range [-4, 4).
- N_ITER, 17, iterations: shift schedule 1,2,3,4,4,5,…,13,13,14,15 (4 and 13 repeated).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- start  in  1  request; sampled only in IDLE.
- a_in  in  20  operand, signed Q2.17.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse when result/err are valid.
- result  out  20  sqrt result, Q2.17; held until next done.
- err  out  1  out-of-range flag; valid with done and held with result.
- sh_amt  out  4  current shift index, driven to both shifters.
- x_q  out  20  x register, feeds x shifter input.
- y_q  out  20  y register, feeds y shifter input.
- x_sh  in  20  arithmetic x_q >> sh_amt, returned combinationally.
- y_sh  in  20  arithmetic y_q >> sh_amt, returned combinationally.

Behaviour:
- Reset (rst_n=0 at clk edge), all outputs and registers:
  - busy=0, done=0, result=0, err=0, sh_amt=0, x_q=0, y_q=0, count=0, state=IDLE.
  - Reset mid-operation aborts immediately; no done is produced.
- States and transitions:
  - IDLE: wait for start.
  - ITER: one iteration per cycle.
  - COMP: present only with GAIN_COMP_EN.
  - FIN: asserts done for one cycle, then returns to IDLE.
- IDLE with start=1:
  - Range check fails (a_in <= 0, or a_in > 0x40000, i.e. > 2.0): set err=1, result=0, go to FIN.
  - Otherwise: x_q <= a_in + 0x08000 (+0.25), y_q <= a_in - 0x08000, count <= 0, err <= 0, go to ITER.
- sh_amt is a combinational lookup of count through the schedule table (count 0 → 1; counts 3,4 → 4; counts 13,14 → 13; count 16 → 15).
- ITER, per cycle:
  - If y_q[19]=1: x_q <= x_q + y_sh, y_q <= y_q + x_sh.
  - Else: x_q <= x_q - y_sh, y_q <= y_q - x_sh.
  - Both updates use old register values.
  - Arithmetic is 20-bit wrap-around, truncating; no saturation inside the loop.
- At count = N_ITER-1 the iteration completes, then:
  - without the optional feature: result <= updated x, go to FIN;
  - with it: go to COMP.
- done=1 exactly during the FIN cycle.
- Latency from the start-sampling edge to done high:
  - 18 cycles valid, base build.
  - 19 cycles with GAIN_COMP_EN.
  - 1 cycle on err.
- start while busy is ignored; no queuing.
- start held high through FIN does not retrigger until the IDLE cycle that follows.
- a_in is sampled only at the start edge; later changes have no effect.
- busy=1 in ITER, COMP and FIN.
- result keeps its previous value during a new operation until the next done.

Optional Feature:
- Macro: CORDIC_GAIN_COMP_EN.
- Defined: adds COMP state (1 cycle). It sets result <= x + (x>>>3) + (x>>>4) + (x>>>6) + (x>>>8) + (x>>>11), approximating the factor 1/K_h ≈ 1.20752, so result ≈ sqrt(a).
  - The shift-adds are local fixed shifts, not the external shifters.
  - Saturate to 0x7FFFF on positive overflow.
- Undefined: no COMP state; result = K_h·sqrt(a), K_h ≈ 0.82816.

Decomposition:
- Package cordic_pkg holds:
  - W, FRAC, N_ITER;
  - state encoding (IDLE, ITER, COMP, FIN);
  - Q2.17 constants QUARTER=0x08000 and MAX_IN=0x40000;
  - the 17-entry shift-schedule constant.
- Sub-module cordic_iter_sched: count register, schedule lookup driving sh_amt, and last-iteration flag.
- Shifters stay external; this block only drives sh_amt/x_q/y_q and consumes x_sh/y_sh.

Test Plan:
- Reset: assert rst_n=0 mid-ITER → next edge busy=0, done=0, result=0, state IDLE; no done afterwards.
- Base build, a_in=0x20000 (1.0) → done at cycle 18, result = 0x1A804 ±8 LSB, err=0.
- GAIN_COMP_EN, a_in=0x08000 (0.25) → done at cycle 19, result = 0x10000 ±16 LSB (0.5).
- GAIN_COMP_EN, a_in=0x40000 (2.0) → result = 0x2D413 ±16 LSB (1.41421).
- Range errors:
  - a_in=0x00000 → done after 1 cycle, err=1, result=0.
  - a_in=0x40001 → done after 1 cycle, err=1, result=0.
  - a_in=0xFFFFF (negative) → done after 1 cycle, err=1, result=0.
- Protocol:
  - Pulse start again during ITER → ignored, a single done.
  - Check the sh_amt sequence 1,2,3,4,4,…,13,13,14,15.
  - Back-to-back start in the IDLE cycle after FIN is accepted.
